// File: rtl/stats_pkg.sv
// rtl/stats_pkg.sv - shared types, register offsets and decode helpers for the branch-statistics window controller
package stats_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] OFF_WIN_LEN    = 16'd0;
    localparam logic [15:0] OFF_SNAP_BR    = 16'd1;
    localparam logic [15:0] OFF_SNAP_HIT   = 16'd2;
    localparam logic [15:0] OFF_CTRL       = 16'd3;
    localparam logic [15:0] OFF_SNAP_MISPR = 16'd4;
    localparam logic [15:0] OFF_SNAP_CYC   = 16'd5;
    localparam logic [15:0] WIN_WORDS      = 16'd6;

    localparam int START_B = 0;
    localparam int STOP_B  = 1;
    localparam int ACK_B   = 2;

    // Addresses below the base wrap to large offsets, so one compare covers both ends.
    function automatic logic [15:0] win_off(input logic [15:0] addr, input logic [15:0] base);
        return addr - base;
    endfunction

    function automatic logic in_win(input logic [15:0] off);
        return off < WIN_WORDS;
    endfunction

endpackage

// File: rtl/stats_rd_mux.sv
// rtl/stats_rd_mux.sv - address decode and registered read mux for the statistics register window
module stats_rd_mux
    import stats_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC008,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      addr,
    input  logic             re,
    input  logic [CNT_W-1:0] win_len,
    input  logic [CNT_W-1:0] snap_br,
    input  logic [CNT_W-1:0] snap_hit,
    input  logic [CNT_W-1:0] snap_mispr,
    input  logic [CNT_W-1:0] snap_cyc,
    input  logic [15:0]      status,
    output logic [15:0]      rdata,
    output logic             rd_vld
);

    logic [15:0] off;
    logic        rd_hit;
    logic [15:0] rd_next;

    always_comb begin
        off     = win_off(addr, BASE_ADDR);
        rd_hit  = re && in_win(off);
        rd_next = 16'h0000;
        case (off)
            OFF_WIN_LEN:    rd_next = 16'(win_len);
            OFF_SNAP_BR:    rd_next = 16'(snap_br);
            OFF_SNAP_HIT:   rd_next = 16'(snap_hit);
            OFF_CTRL:       rd_next = status;
            OFF_SNAP_MISPR: rd_next = 16'(snap_mispr);
            OFF_SNAP_CYC:   rd_next = 16'(snap_cyc);
            default:        rd_next = 16'h0000;
        endcase
    end

    // rdata is only reloaded on an in-window read so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= 16'h0000;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_hit;
            if (rd_hit) begin
                rdata <= rd_next;
            end
        end
    end

endmodule

// File: rtl/stats_ctrl.sv
// rtl/stats_ctrl.sv - measurement-window FSM, cycle counter and atomic snapshots for the branch counters
module stats_ctrl
    import stats_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC008,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      addr,
    input  logic             we,
    input  logic             re,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    output logic             rd_vld,
    input  logic [CNT_W-1:0] br_cnt,
    input  logic [CNT_W-1:0] hit_cnt,
    input  logic [CNT_W-1:0] mispr_cnt,
    output logic             stats_en,
    output logic             cnt_clr,
    output logic             done_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] win_len, remaining, cyc;
    logic [CNT_W-1:0] snap_br, snap_hit, snap_mispr, snap_cyc;
    logic             ovf, free_run, busy;
    logic [15:0]      wr_off, status;
    logic             wr_ctrl, start, stop, ack, any_max;

    assign wr_off  = win_off(addr, BASE_ADDR);
    assign wr_ctrl = we && (wr_off == OFF_CTRL);
    assign start   = wr_ctrl && wdata[START_B];
    assign stop    = wr_ctrl && wdata[STOP_B];
    assign ack     = wr_ctrl && wdata[ACK_B];
    assign any_max = (br_cnt == CNT_MAX) || (hit_cnt == CNT_MAX) || (mispr_cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: state_nxt = RUN;
            RUN:   if (stop || (!free_run && remaining == CNT_W'(1))) state_nxt = DRAIN;
            DRAIN: state_nxt = DONE;
            DONE: begin
                if (start)    state_nxt = CLEAR;
                else if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // remaining and free_run are latched in CLEAR so WIN_LEN writes never disturb a live window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_len    <= '0;
            remaining  <= '0;
            free_run   <= 1'b0;
            cyc        <= '0;
            ovf        <= 1'b0;
            snap_br    <= '0;
            snap_hit   <= '0;
            snap_mispr <= '0;
            snap_cyc   <= '0;
        end else begin
            state <= state_nxt;
            if (we && wr_off == OFF_WIN_LEN) begin
                win_len <= CNT_W'(wdata);
            end
            case (state)
                CLEAR: begin
                    cyc       <= '0;
                    ovf       <= 1'b0;
                    remaining <= win_len;
                    free_run  <= (win_len == '0);
                end
                RUN: begin
                    if (cyc != CNT_MAX)      cyc <= cyc + CNT_W'(1);
                    if (remaining != '0)     remaining <= remaining - CNT_W'(1);
                    if (any_max)             ovf <= 1'b1;
                end
                DRAIN: begin
                    snap_br    <= br_cnt;
                    snap_hit   <= hit_cnt;
                    snap_mispr <= mispr_cnt;
                    snap_cyc   <= cyc;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == CLEAR) || (state == RUN) || (state == DRAIN);
    assign stats_en = (state == RUN);
    assign cnt_clr  = (state == CLEAR);
    assign done_irq = (state == DONE);
    assign status   = {11'b0, ovf, state, busy};

    stats_rd_mux #(
        .BASE_ADDR (BASE_ADDR),
        .CNT_W     (CNT_W)
    ) u_rd_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .re         (re),
        .win_len    (win_len),
        .snap_br    (snap_br),
        .snap_hit   (snap_hit),
        .snap_mispr (snap_mispr),
        .snap_cyc   (snap_cyc),
        .status     (status),
        .rdata      (rdata),
        .rd_vld     (rd_vld)
    );

endmodule

// File: tb/tb_stats_ctrl.sv
// tb/tb_stats_ctrl.sv - scoreboard bench for the statistics window controller
module tb_stats_ctrl;

    localparam logic [15:0] BASE = 16'hC008;
    localparam logic [15:0] CTRL = BASE + 16'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr, wdata, rdata;
    logic        we, re, rd_vld;
    logic [15:0] br_cnt, hit_cnt, mispr_cnt;
    logic        stats_en, cnt_clr, done_irq;

    typedef struct {
        logic [15:0] data;
        int          cyc;
        string       name;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    rd_exp_t e;
    int compared   = 0;
    int mismatched = 0;
    int cyc_n      = 0;
    int en_cnt     = 0;
    int clr_cnt    = 0;
    int base_en, base_clr, n;

    stats_ctrl #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .we        (we),
        .re        (re),
        .wdata     (wdata),
        .rdata     (rdata),
        .rd_vld    (rd_vld),
        .br_cnt    (br_cnt),
        .hit_cnt   (hit_cnt),
        .mispr_cnt (mispr_cnt),
        .stats_en  (stats_en),
        .cnt_clr   (cnt_clr),
        .done_irq  (done_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_n++;
        if (stats_en) en_cnt++;
        if (cnt_clr)  clr_cnt++;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] off, input logic [15:0] exp, input string name);
        rd_q.push_back('{exp, cyc_n + 1, name});
        re = 1'b1; addr = BASE + off;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic rd_none(input logic [15:0] a, input string name);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        chk(name, {15'b0, rd_vld}, 16'h0000);
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 200 && !done_irq; k++) @(negedge clk);
        chk(name, {15'b0, done_irq}, 16'h0001);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rd_vld) begin
                    if (rd_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_rd_vld: got rdata %h with no read pending", rdata);
                    end else begin
                        e = rd_q.pop_front();
                        chk(e.name, rdata, e.data);
                        chk({e.name, "_latency"}, 16'(cyc_n), 16'(e.cyc));
                    end
                end
            end
        join_none

        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 16'h0; wdata = 16'h0;
        br_cnt = 16'd7; hit_cnt = 16'd5; mispr_cnt = 16'd2;
        repeat (3) @(negedge clk);
        chk("reset_stats_en", {15'b0, stats_en}, 16'h0);
        chk("reset_cnt_clr", {15'b0, cnt_clr}, 16'h0);
        chk("reset_done_irq", {15'b0, done_irq}, 16'h0);
        chk("reset_rd_vld", {15'b0, rd_vld}, 16'h0);
        chk("reset_rdata", rdata, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(16'd3, 16'h0000, "status_idle");

        // Fixed 10-cycle window.
        base_en = en_cnt; base_clr = clr_cnt;
        wr(BASE, 16'd10);
        wr(CTRL, 16'h0001);
        wait_done("done_win10");
        chk("stats_en_cycles_10", 16'(en_cnt - base_en), 16'd10);
        chk("cnt_clr_pulses", 16'(clr_cnt - base_clr), 16'd1);
        rd(16'd1, 16'd7, "snap_br");
        rd(16'd2, 16'd5, "snap_hit");
        rd(16'd4, 16'd2, "snap_mispr");
        rd(16'd5, 16'd10, "snap_cyc_10");
        rd(16'd3, 16'h0008, "status_done");
        rd(16'd0, 16'd10, "win_len_rb");
        rd_none(BASE + 16'd6, "no_rd_above");
        rd_none(BASE - 16'd1, "no_rd_below");

        // Free-running window stopped after 37 RUN cycles; WIN_LEN rewritten mid-window.
        wr(BASE, 16'd0);
        base_en = en_cnt;
        wr(CTRL, 16'h0001);
        n = 0;
        for (int k = 0; k < 300 && n < 37; k++) begin
            @(negedge clk);
            we = 1'b0;
            if (stats_en) n++;
            if (stats_en && n == 10) begin
                we = 1'b1; addr = BASE; wdata = 16'd3;
            end
            if (n == 37) begin
                we = 1'b1; addr = CTRL; wdata = 16'h0002;
            end
        end
        @(negedge clk);
        we = 1'b0;
        wait_done("done_free_run");
        chk("stats_en_cycles_37", 16'(en_cnt - base_en), 16'd37);
        rd(16'd5, 16'd37, "snap_cyc_37");
        wr(CTRL, 16'h0002);
        rd(16'd3, 16'h0008, "status_done_after_stop");
        chk("done_irq_after_stop", {15'b0, done_irq}, 16'h0001);
        rd(16'd0, 16'd3, "win_len_midrun");

        // Acknowledge, then STOP in IDLE is ignored.
        wr(CTRL, 16'h0004);
        chk("done_irq_acked", {15'b0, done_irq}, 16'h0000);
        rd(16'd3, 16'h0000, "status_idle_acked");
        wr(CTRL, 16'h0002);
        @(negedge clk);
        chk("stop_idle_stats_en", {15'b0, stats_en}, 16'h0000);
        rd(16'd3, 16'h0000, "status_idle_stop");

        // Overflow: START+STOP in IDLE starts, saturated hit_cnt sets ovf.
        wr(BASE, 16'd5);
        wr(CTRL, 16'h0003);
        @(negedge clk);
        hit_cnt = 16'hFFFF;
        @(negedge clk);
        hit_cnt = 16'd5;
        wait_done("done_ovf");
        rd(16'd3, 16'h0018, "status_ovf");
        rd(16'd5, 16'd5, "snap_cyc_5");
        wr(CTRL, 16'h0001);
        chk("done_irq_restart", {15'b0, done_irq}, 16'h0000);
        @(negedge clk);
        rd(16'd3, 16'h0005, "status_ovf_cleared");
        wait_done("done_after_restart");
        wr(CTRL, 16'h0004);

        // Asynchronous reset in the third RUN cycle.
        wr(BASE, 16'd20);
        wr(CTRL, 16'h0001);
        n = 0;
        for (int k = 0; k < 50 && n < 3; k++) begin
            @(negedge clk);
            if (stats_en) n++;
        end
        chk("run_cycle_3", 16'(n), 16'd3);
        rst_n = 1'b0;
        #1;
        chk("async_stats_en", {15'b0, stats_en}, 16'h0000);
        chk("async_done_irq", {15'b0, done_irq}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(16'd1, 16'h0000, "rst_snap_br");
        rd(16'd2, 16'h0000, "rst_snap_hit");
        rd(16'd4, 16'h0000, "rst_snap_mispr");
        rd(16'd5, 16'h0000, "rst_snap_cyc");
        rd(16'd0, 16'h0000, "rst_win_len");
        rd(16'd3, 16'h0000, "rst_status");

        repeat (3) @(negedge clk);
        if (rd_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL reads_outstanding: got %0d pending expected 0", rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
